// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch front-end
// Purpose: RV32 widths, fetch FSM state encoding, instruction buffer entry layout
//          and the sequential PC step helper.
// Ports:   none (package).
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [0:0] {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Sequential word step; wraps 32'hFFFF_FFFC -> 32'h0000_0000 naturally.
  function automatic logic [XLEN-1:0] next_fetch_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// rtl/instr_fetch_unit_fifo.sv - synchronous FIFO used for the instruction buffer and address queue
// Purpose: DEPTH-entry (power of two) FIFO with flush; head is read combinationally.
//          A push is accepted when full only if a pop happens in the same cycle.
//          Flush has priority over push and pop.
// Ports:   clk, rst_n       clock, asynchronous active-low reset
//          flush_i          empty the FIFO this cycle
//          push_i/_data_i   write one entry
//          pop_i            drop the head entry (ignored when empty)
//          head_data_o      current head entry
//          count_o          number of valid entries (0..DEPTH)
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty       = (count_q == '0);
  assign full        = (count_q == (AW+1)'(DEPTH));
  assign do_pop      = pop_i && !empty;
  assign do_push     = push_i && (!full || do_pop);
  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I instruction fetch front-end
// Purpose: owns the fetch PC, issues word reads under a credit limit, tags in-order
//          responses with their request address, buffers them and presents {instr, pc}
//          to decode. A redirect flushes the buffer and discards wrong-path responses.
// Optional feature: FETCH_MISALIGN_CHECK_EN - misaligned redirect targets halt fetch
//          and raise fetch_misalign; otherwise target bits [1:0] are forced to zero.
// Ports:   clk, rst_n                       clock, asynchronous active-low reset
//          imem_req_valid/ready/addr        fetch request channel
//          imem_rsp_valid/data              in-order response words
//          redirect_valid/pc                control-flow redirect pulse and target
//          out_valid/ready/instr/pc         decode-side instruction stream
//          fetch_misalign                   misaligned redirect target held
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fetch_misalign
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            issue_en_q;

  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] rsp_pc;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_push_entry;
  logic [XLEN-1:0] target_pc;
  logic            target_bad;
  logic            req_fire;
  logic            rsp_drop;
  logic            buf_push;
  logic            buf_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target_pc      = redirect_pc;
  assign target_bad     = (redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = (state_q == FETCH_HALT);
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_pc[1:0];
  assign target_pc          = {redirect_pc[XLEN-1:2], 2'b00};
  assign target_bad         = 1'b0;
  assign fetch_misalign     = 1'b0;
`endif

  // Credit counts both in-flight requests and buffered words, so every
  // response is guaranteed a buffer slot and the request stays asserted
  // until accepted (credit can only grow while a request waits).
  assign credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req_valid = issue_en_q && (state_q == FETCH_RUN) && !redirect_valid
                          && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop       = (drop_cnt_q != '0);
  assign buf_push       = imem_rsp_valid && !rsp_drop && !redirect_valid;
  assign buf_push_entry = '{pc: rsp_pc, instr: imem_rsp_data};
  // The flush on redirect overrides this pop inside the FIFO.
  assign buf_pop        = out_valid && out_ready;

  assign out_valid = (buf_count != '0);
  assign out_instr = out_valid ? buf_head.instr : '0;
  assign out_pc    = (state_q == FETCH_HALT) ? fetch_pc_q
                   : (out_valid ? buf_head.pc : '0);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      // Everything still in flight is wrong-path; a response arriving right
      // now is already discarded by the flush.
      drop_cnt_d = outstanding - CW'(imem_rsp_valid);
      state_d    = target_bad ? FETCH_HALT : FETCH_RUN;
    end else begin
      if (req_fire) begin
        fetch_pc_d = next_fetch_pc(fetch_pc_q);
      end
      if (imem_rsp_valid && rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_RUN;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
      issue_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
      issue_en_q <= 1'b1;
    end
  end

  // Request-address queue: one entry per accepted request, popped by every
  // response (dropped or not); its occupancy is the outstanding count.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_addr_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (1'b0),
    .push_i      (req_fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (imem_rsp_valid),
    .head_data_o (rsp_pc),
    .count_o     (outstanding)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (buf_push),
    .push_data_i (buf_push_entry),
    .pop_i       (buf_pop),
    .head_data_o (buf_head),
    .count_o     (buf_count)
  );

  // A response with nothing outstanding is a memory-side protocol error.
  a_rsp_has_request : assert property (
    @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (outstanding != '0)
  );

endmodule
